// File: rtl/sevenseg_pkg.sv
// ---------------------------------------------------------------------------
// sevenseg_pkg
// Shared definitions for the multiplexed seven-segment scanner.
//   - Active-low 7-segment glyphs (bits 6..0 = a,b,c,d,e,f,g) for 0-9, A-F
//   - SEG_BLANK: the all-dark cathode pattern
//   - digit_t: one stored digit (code, decimal point, blank flag)
//   - seg_glyph(): code + dp -> full 8-bit active-low cathode pattern
// ---------------------------------------------------------------------------
package sevenseg_pkg;

  localparam logic [6:0] GLYPH_0   = 7'b0000001;
  localparam logic [6:0] GLYPH_1   = 7'b1001111;
  localparam logic [6:0] GLYPH_2   = 7'b0010010;
  localparam logic [6:0] GLYPH_3   = 7'b0000110;
  localparam logic [6:0] GLYPH_4   = 7'b1001100;
  localparam logic [6:0] GLYPH_5   = 7'b0100100;
  localparam logic [6:0] GLYPH_6   = 7'b0100000;
  localparam logic [6:0] GLYPH_7   = 7'b0001111;
  localparam logic [6:0] GLYPH_8   = 7'b0000000;
  localparam logic [6:0] GLYPH_9   = 7'b0000100;
  localparam logic [6:0] GLYPH_A   = 7'b0001000;
  localparam logic [6:0] GLYPH_B   = 7'b1100000;
  localparam logic [6:0] GLYPH_C   = 7'b0110001;
  localparam logic [6:0] GLYPH_D   = 7'b1000010;
  localparam logic [6:0] GLYPH_E   = 7'b0110000;
  localparam logic [6:0] GLYPH_F   = 7'b0111000;
  localparam logic [6:0] GLYPH_OFF = 7'b1111111;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef struct packed {
    logic [3:0] code;
    logic       dp;
    logic       blank;
  } digit_t;

  // Digits come out of reset dark: code 0, no decimal point, blanked.
  localparam digit_t DIGIT_RESET = '{code: 4'h0, dp: 1'b0, blank: 1'b1};

  // Maps a 4-bit code to its active-low pattern. Bit 7 is the decimal
  // point, also active low. Letters only render when hex_en is set;
  // otherwise they fall through to an unlit digit (dp still honoured).
  function automatic logic [7:0] seg_glyph(input logic [3:0] code,
                                           input logic       dp,
                                           input logic       hex_en);
    logic [6:0] segs;
    segs = GLYPH_OFF;
    case (code)
      4'h0: segs = GLYPH_0;
      4'h1: segs = GLYPH_1;
      4'h2: segs = GLYPH_2;
      4'h3: segs = GLYPH_3;
      4'h4: segs = GLYPH_4;
      4'h5: segs = GLYPH_5;
      4'h6: segs = GLYPH_6;
      4'h7: segs = GLYPH_7;
      4'h8: segs = GLYPH_8;
      4'h9: segs = GLYPH_9;
      4'hA: segs = hex_en ? GLYPH_A : GLYPH_OFF;
      4'hB: segs = hex_en ? GLYPH_B : GLYPH_OFF;
      4'hC: segs = hex_en ? GLYPH_C : GLYPH_OFF;
      4'hD: segs = hex_en ? GLYPH_D : GLYPH_OFF;
      4'hE: segs = hex_en ? GLYPH_E : GLYPH_OFF;
      default: segs = hex_en ? GLYPH_F : GLYPH_OFF;
    endcase
    return {~dp, segs};
  endfunction

endpackage

// File: rtl/sevenseg_glyph_rom.sv
// ---------------------------------------------------------------------------
// sevenseg_glyph_rom
// Combinational lookup from one stored digit to its cathode pattern.
//   i_code    [3:0] : digit code
//   i_dp            : decimal point on
//   i_blank         : forces the whole digit (including dp) dark
//   o_cathode [7:0] : active-low pattern, bit 7 = dp, bits 6..0 = a..g
// ---------------------------------------------------------------------------
module sevenseg_glyph_rom
  import sevenseg_pkg::*;
#(
  parameter int HEX_EN = 0
) (
  input  logic [3:0] i_code,
  input  logic       i_dp,
  input  logic       i_blank,
  output logic [7:0] o_cathode
);

  // A blanked digit wins over both the code and the decimal point, so a
  // digit can be parked dark without clearing its contents.
  always_comb begin
    o_cathode = SEG_BLANK;
    if (!i_blank) begin
      o_cathode = seg_glyph(i_code, i_dp, (HEX_EN != 0));
    end
  end

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// sevenseg_scan_ctrl
// Time-multiplexed driver for NUM_DIGITS common-anode seven-segment digits
// with per-slot brightness (PWM within the slot) and optional hex glyphs.
//   clk, rst          : system clock, synchronous active-high reset
//   wr_en             : write strobe, one digit per cycle
//   wr_digit          : target digit (NUM_DIGITS-1 = leftmost); out-of-range
//                       indices are ignored
//   wr_value/dp/blank : new contents for that digit
//   brightness        : on-phases per slot minus one (all ones = full on),
//                       sampled at each slot boundary
//   anodeOutput       : active-low digit enables
//   cathodeOutput     : active-low segments, bit 7 = dp, bits 6..0 = a..g
//   scan_tick         : one-cycle pulse while the newly selected slot is held
// All outputs are registered.
// ---------------------------------------------------------------------------
module sevenseg_scan_ctrl
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int CYCLE_BITS   = 21,
  parameter int DIGIT_PERIOD = 400000,
  parameter int BRIGHT_BITS  = 3,
  parameter int HEX_EN       = 0,
  parameter int IDX_W        = $clog2(NUM_DIGITS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [IDX_W-1:0]       wr_digit,
  input  logic [3:0]             wr_value,
  input  logic                   wr_dp,
  input  logic                   wr_blank,
  input  logic [BRIGHT_BITS-1:0] brightness,
  output logic [NUM_DIGITS-1:0]  anodeOutput,
  output logic [7:0]             cathodeOutput,
  output logic                   scan_tick
);

  localparam int                    SUB_PERIOD = DIGIT_PERIOD >> BRIGHT_BITS;
  localparam logic [CYCLE_BITS-1:0] CNT_LAST   = CYCLE_BITS'(DIGIT_PERIOD - 1);
  localparam logic [CYCLE_BITS-1:0] SUB_LAST   = CYCLE_BITS'(SUB_PERIOD - 1);
  localparam logic [IDX_W-1:0]      SLOT_FIRST = IDX_W'(NUM_DIGITS - 1);

  digit_t                 r_store [NUM_DIGITS];
  logic [CYCLE_BITS-1:0]  r_cnt;
  logic [CYCLE_BITS-1:0]  r_subCnt;
  logic [BRIGHT_BITS-1:0] r_phase;
  logic [IDX_W-1:0]       r_slot;
  logic [BRIGHT_BITS-1:0] r_brightQ;
  logic [NUM_DIGITS-1:0]  r_anode;
  logic [7:0]             r_cathode;
  logic                   r_scanTick;

  logic [CYCLE_BITS-1:0]  w_cntNext;
  logic [CYCLE_BITS-1:0]  w_subNext;
  logic [BRIGHT_BITS-1:0] w_phaseNext;
  logic [IDX_W-1:0]       w_slotNext;
  logic                   w_slotWrap;
  digit_t                 w_digit;
  logic [7:0]             w_glyph;
  logic                   w_phaseOn;
  logic [NUM_DIGITS-1:0]  w_anodeSel;

  // Digit store. Each digit compares its own index against wr_digit, so an
  // index beyond the last digit simply matches nothing and is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        r_store[i] <= DIGIT_RESET;
      end
    end else if (wr_en) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (wr_digit == IDX_W'(i)) begin
          r_store[i] <= '{code: wr_value, dp: wr_dp, blank: wr_blank};
        end
      end
    end
  end

  // Next-state logic for the slot counter, the PWM phase and the slot
  // down-counter. The phase is kept by its own sub-counter because the
  // per-phase length need not be a power of two.
  always_comb begin
    w_slotWrap  = (r_cnt == CNT_LAST);
    w_cntNext   = r_cnt + CYCLE_BITS'(1);
    w_subNext   = r_subCnt + CYCLE_BITS'(1);
    w_phaseNext = r_phase;
    w_slotNext  = r_slot;
    if (w_slotWrap) begin
      w_cntNext   = '0;
      w_subNext   = '0;
      w_phaseNext = '0;
      w_slotNext  = (r_slot == '0) ? SLOT_FIRST : (r_slot - IDX_W'(1));
    end else if (r_subCnt == SUB_LAST) begin
      w_subNext   = '0;
      w_phaseNext = r_phase + BRIGHT_BITS'(1);
    end
  end

  // Scan state registers. Brightness is only captured at the slot boundary
  // so a digit never changes intensity partway through its slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_subCnt   <= '0;
      r_phase    <= '0;
      r_slot     <= SLOT_FIRST;
      r_brightQ  <= '1;
      r_scanTick <= 1'b0;
    end else begin
      r_cnt      <= w_cntNext;
      r_subCnt   <= w_subNext;
      r_phase    <= w_phaseNext;
      r_slot     <= w_slotNext;
      r_scanTick <= w_slotWrap;
      if (w_slotWrap) begin
        r_brightQ <= brightness;
      end
    end
  end

  assign w_digit    = r_store[r_slot];
  assign w_phaseOn  = (r_phase <= r_brightQ);
  assign w_anodeSel = ~(NUM_DIGITS'(1) << r_slot);

  sevenseg_glyph_rom #(
    .HEX_EN(HEX_EN)
  ) u_glyphRom (
    .i_code   (w_digit.code),
    .i_dp     (w_digit.dp),
    .i_blank  (w_digit.blank),
    .o_cathode(w_glyph)
  );

  // Output registers. During the off phases both the anode and the
  // cathodes are released so the next digit's pattern cannot ghost.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_anode   <= '1;
      r_cathode <= SEG_BLANK;
    end else begin
      r_anode   <= w_phaseOn ? w_anodeSel : '1;
      r_cathode <= w_phaseOn ? w_glyph : SEG_BLANK;
    end
  end

  assign anodeOutput   = r_anode;
  assign cathodeOutput = r_cathode;
  assign scan_tick     = r_scanTick;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sevenseg_scan_ctrl
// Directed bench for sevenseg_scan_ctrl with DIGIT_PERIOD=8, BRIGHT_BITS=2.
//   dutA : 4 digits, hex glyphs off (scan, writes, brightness, collision,
//          reset mid-slot)
//   dutB : 6 digits, hex glyphs on (hex rendering, out-of-range write)
// Cycle index k counts clock edges since the last reset release; the output
// seen after edge k belongs to slot 3-((k-1)/8 mod 4), cycle (k-1) mod 8.
// ---------------------------------------------------------------------------
module tb_sevenseg_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] brightness;

  logic       aWrEn;
  logic [1:0] aWrDigit;
  logic [3:0] aWrValue;
  logic       aWrDp;
  logic       aWrBlank;
  logic [3:0] anodeA;
  logic [7:0] cathodeA;
  logic       tickA;

  logic       bWrEn;
  logic [2:0] bWrDigit;
  logic [3:0] bWrValue;
  logic       bWrDp;
  logic       bWrBlank;
  logic [5:0] anodeB;
  logic [7:0] cathodeB;
  logic       tickB;

  int         checks   = 0;
  int         failures = 0;
  int         k        = 0;
  logic [1:0] bqModel  = 2'b11;
  logic [1:0] bqPrev   = 2'b11;
  logic [7:0] expGlyph [4];

  sevenseg_scan_ctrl #(
    .NUM_DIGITS(4), .CYCLE_BITS(4), .DIGIT_PERIOD(8), .BRIGHT_BITS(2), .HEX_EN(0)
  ) dutA (
    .clk(clk), .rst(rst), .wr_en(aWrEn), .wr_digit(aWrDigit), .wr_value(aWrValue),
    .wr_dp(aWrDp), .wr_blank(aWrBlank), .brightness(brightness),
    .anodeOutput(anodeA), .cathodeOutput(cathodeA), .scan_tick(tickA)
  );

  sevenseg_scan_ctrl #(
    .NUM_DIGITS(6), .CYCLE_BITS(4), .DIGIT_PERIOD(8), .BRIGHT_BITS(2), .HEX_EN(1)
  ) dutB (
    .clk(clk), .rst(rst), .wr_en(bWrEn), .wr_digit(bWrDigit), .wr_value(bWrValue),
    .wr_dp(bWrDp), .wr_blank(bWrBlank), .brightness(brightness),
    .anodeOutput(anodeB), .cathodeOutput(cathodeB), .scan_tick(tickB)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Safety net so a broken design can never hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  // One clock edge. Brightness is captured by the DUT on wrap edges, so the
  // model latches it here too; bqPrev is the value in force for this edge.
  task automatic applyStimulus();
    bqPrev = bqModel;
    if ((k + 1) % 8 == 0) bqModel = brightness;
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic checkValue(input string tag, input logic [7:0] observed,
                            input logic [7:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        failures++;
        $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
  endtask

  // Compares dutA against the slot/phase model for the current edge k.
  task automatic checkOutput();
    int         s;
    int         c;
    int         ph;
    logic       on;
    logic [3:0] sel;
    logic [3:0] expAnode;
    logic [7:0] expCath;
    s        = 3 - (((k - 1) / 8) % 4);
    c        = (k - 1) % 8;
    ph       = c / 2;
    on       = (ph <= int'(bqPrev));
    sel      = 4'b0001 << s;
    expAnode = on ? ~sel : 4'hF;
    expCath  = on ? expGlyph[s] : 8'hFF;
    checkValue($sformatf("anode k=%0d", k), {4'h0, anodeA}, {4'h0, expAnode});
    checkValue($sformatf("cathode k=%0d", k), cathodeA, expCath);
    checkValue($sformatf("tick k=%0d", k), {7'h0, tickA}, {7'h0, (k % 8 == 0)});
  endtask

  task automatic checkReset(input string tag);
    checkValue({tag, " anodeA"}, {4'h0, anodeA}, 8'h0F);
    checkValue({tag, " cathodeA"}, cathodeA, 8'hFF);
    checkValue({tag, " tickA"}, {7'h0, tickA}, 8'h00);
    checkValue({tag, " anodeB"}, {2'h0, anodeB}, 8'h3F);
    checkValue({tag, " cathodeB"}, cathodeB, 8'hFF);
  endtask

  initial begin
    rst = 1'b1; brightness = 2'b11;
    aWrEn = 1'b0; aWrDigit = '0; aWrValue = '0; aWrDp = 1'b0; aWrBlank = 1'b0;
    bWrEn = 1'b0; bWrDigit = '0; bWrValue = '0; bWrDp = 1'b0; bWrBlank = 1'b0;
    for (int i = 0; i < 4; i++) expGlyph[i] = 8'hFF;

    // Reset held for three cycles
    repeat (3) applyStimulus();
    checkReset("reset");
    $display("[TB] reset released, scanning blank digits");

    // Release; dutB gets A on its leftmost digit, then a write to index 7
    rst = 1'b0; k = 0; bqModel = 2'b11;
    bWrEn = 1'b1; bWrDigit = 3'd5; bWrValue = 4'hA; bWrBlank = 1'b0;
    for (int i = 1; i <= 49; i++) begin
      applyStimulus();
      checkOutput();
      if (k == 1) begin
        checkValue("hexB before visible", cathodeB, 8'hFF);
        bWrDigit = 3'd7; bWrValue = 4'h8;
      end
      if (k == 2) begin
        checkValue("hexB glyph A", cathodeB, 8'h88);
        checkValue("hexB anode", {2'h0, anodeB}, 8'h1F);
        bWrEn = 1'b0;
      end
      if (k == 8) checkValue("tickB", {7'h0, tickB}, 8'h01);
      if (k == 9 || k == 17 || k == 25 || k == 33 || k == 41)
        checkValue($sformatf("rangeB blank k=%0d", k), cathodeB, 8'hFF);
      if (k == 49) checkValue("hexB persists", cathodeB, 8'h88);
    end

    // Writes: 3 -> digit 3, 5 with dp -> digit 0, A with dp -> digit 1
    $display("[TB] writing digits");
    aWrEn = 1'b1; aWrDigit = 2'd3; aWrValue = 4'h3; aWrDp = 1'b0; aWrBlank = 1'b0;
    applyStimulus(); checkOutput(); expGlyph[3] = 8'h86;
    aWrDigit = 2'd0; aWrValue = 4'h5; aWrDp = 1'b1;
    applyStimulus(); checkOutput(); expGlyph[0] = 8'h24;
    aWrDigit = 2'd1; aWrValue = 4'hA; aWrDp = 1'b1;
    applyStimulus(); checkOutput(); expGlyph[1] = 8'h7F;
    aWrEn = 1'b0; aWrDp = 1'b0;
    while (k < 92) begin
      applyStimulus(); checkOutput();
    end

    // Brightness changed mid-slot: 1, then 0, then back to full
    $display("[TB] brightness steps");
    brightness = 2'd1;
    while (k < 130) begin
      applyStimulus(); checkOutput();
    end
    brightness = 2'd0;
    while (k < 160) begin
      applyStimulus(); checkOutput();
    end
    brightness = 2'd3;

    // Write digit 2 on the same edge the scan advances from slot 3 to 2
    while (k % 32 != 7) begin
      applyStimulus(); checkOutput();
    end
    aWrEn = 1'b1; aWrDigit = 2'd2; aWrValue = 4'h9; aWrDp = 1'b0; aWrBlank = 1'b0;
    applyStimulus(); checkOutput(); expGlyph[2] = 8'h84;
    aWrEn = 1'b0;
    applyStimulus(); checkOutput();
    checkValue("collision first cathode", cathodeA, 8'h84);

    // Reset with a pending write, halfway through slot 1
    while (k % 32 != 20) begin
      applyStimulus(); checkOutput();
    end
    $display("[TB] reset mid-slot with write pending");
    rst = 1'b1; aWrEn = 1'b1; aWrDigit = 2'd1; aWrValue = 4'h8; aWrBlank = 1'b0;
    applyStimulus();
    checkReset("midreset");
    rst = 1'b0; aWrEn = 1'b0; k = 0; bqModel = 2'b11;
    for (int i = 0; i < 4; i++) expGlyph[i] = 8'hFF;
    for (int i = 1; i <= 33; i++) begin
      applyStimulus(); checkOutput();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/sevenseg_scan_ctrl.md
# sevenseg_scan_ctrl

Parametrised multiplexed seven-segment display controller. It stores one 4-bit code, one blank flag and one decimal-point flag per digit, written through a single-cycle write port. It time-multiplexes `NUM_DIGITS` common-anode digits with programmable per-slot brightness and optional hex glyphs. It sits between the timer/counter logic and the board's anode/cathode pins, and is the generalised replacement for the fixed 4-digit scanner.

## Interface
- `NUM_DIGITS`, 4: digits scanned, 2..8.
- `CYCLE_BITS`, 21: width of the slot counter.
- `DIGIT_PERIOD`, 400000: clk cycles per digit slot. Must be a multiple of 2^`BRIGHT_BITS` and less than 2^`CYCLE_BITS`.
- `BRIGHT_BITS`, 3: brightness resolution.
- `HEX_EN`, 0: 1 renders codes A–F as hex glyphs; 0 renders them blank.
- `IDX_W`, $clog2(`NUM_DIGITS`): width of `wr_digit`.
- `clk` in 1: system clock. One clock; reset is synchronous and active-high.
- `rst` in 1: synchronous, active-high reset.
- `wr_en` in 1: write strobe, one digit per cycle.
- `wr_digit` in `IDX_W`: target digit. Index `NUM_DIGITS`-1 is the leftmost digit.
- `wr_value` in 4: digit code.
- `wr_dp` in 1: decimal point on.
- `wr_blank` in 1: 1 blanks the digit regardless of `wr_value`.
- `brightness` in `BRIGHT_BITS`: on-phases per slot minus 1. All ones means full on.
- `anodeOutput` out `NUM_DIGITS`: active-low digit enables.
- `cathodeOutput` out 8: active-low. Bit 7 = DP; bits 6..0 = a,b,c,d,e,f,g.
- `scan_tick` out 1: one-cycle pulse at each slot advance.

## Operation
- State per digit: `code[3:0]`, `dp`, `blank`.
  - Reset value: code 0, dp 0, blank 1 (all digits dark).
- Write handling:
  - A write with `wr_digit` < `NUM_DIGITS` updates all three fields of that digit.
  - A write with `wr_digit` ≥ `NUM_DIGITS` is ignored.
- Scan state:
  - `slot`: the digit currently driven.
  - `cnt`: 0..`DIGIT_PERIOD`-1.
  - `phase`: 0..2^`BRIGHT_BITS`-1. `phase` advances every `DIGIT_PERIOD`>>`BRIGHT_BITS` cycles.
- Slot advance: when `cnt` = `DIGIT_PERIOD`-1, `cnt` wraps to 0 and `scan_tick` pulses.
  - `slot` decrements: N-1 → N-2 → … → 0 → N-1.
  - `brightness` is latched into `bright_q` at this point. A mid-slot change takes effect at the next slot.
- Anode drive: the anode of `slot` is asserted (0) only while `phase` ≤ `bright_q`. All other anodes are 1.
- Cathode drive: cathode = glyph(code, dp), or 8'hFF when blank.
  - While the anode is off, the cathode is forced to 8'hFF (ghosting suppression).
- Glyph encoding (bits 6..0, active low):
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110, 4 = 1001100
  - 5 = 0100100, 6 = 0100000, 7 = 0001111, 8 = 0000000, 9 = 0000100
  - With `HEX_EN`=1: A = 0001000, b = 1100000, C = 0110001, d = 1000010, E = 0110000, F = 0111000.
  - Otherwise codes A–F give 1111111.
  - Bit 7 = ~dp.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Reset (sync; the cycle after `rst` is sampled high):
  - `anodeOutput` all 1s, `cathodeOutput` 8'hFF, `scan_tick` 0.
  - `cnt` 0, `phase` 0, `slot` = `NUM_DIGITS`-1, `bright_q` = all ones.
- First slot after reset: first output-register update after `rst` deasserts drives `slot` N-1. With all digits blank the cathode stays 8'hFF while the anode is 0.
- Write latency: a write sampled at edge t is visible on `cathodeOutput` after edge t+1, provided that digit is being displayed.
- Write plus slot advance in the same cycle: the store is updated and the new slot is selected.
  - Output after t+1 reflects the new slot with post-write contents.
- `scan_tick` is high during the cycle in which `slot` holds its new value; outputs follow one cycle later.
- Reset asserted mid-slot or mid-write: everything returns to reset values on that edge, and the write is dropped.

## Structure
- `sevenseg_pkg`:
  - glyph localparams for 0–9 and A–F
  - `SEG_BLANK` = 8'hFF
  - function `seg_glyph(code, dp, hex_en)`
- Sub-module `sevenseg_glyph_rom` (combinational): code, dp, blank → 8-bit cathode pattern.
- Top level holds: digit store, counters, slot FSM (a down-counter with wrap), brightness compare and output registers.

## Test plan
All scenarios run with `DIGIT_PERIOD`=8 and `BRIGHT_BITS`=2 unless stated.
- Reset scan:
  - Stimulus: hold `rst` 3 cycles, release, no writes.
  - Response: `anodeOutput` walks 0111 → 1011 → 1101 → 1110 → 0111, each for 8 cycles; `cathodeOutput` stays 8'hFF; `scan_tick` pulses every 8 cycles.
- Write and display:
  - Stimulus: write 3,7 to digit 3 and 5,1 to digit 0, with dp=1 on digit 0.
  - Response: slot 3 shows 8'b10000110; slot 0 shows 8'b00100100 (5 with DP on). Digits 2 and 1 show 8'hFF.
- Brightness:
  - Stimulus: `brightness`=1.
  - Response: each anode is low for cycles 0–3 of its slot and high for 4–7; cathode is 8'hFF during 4–7.
  - Stimulus: change `brightness` mid-slot.
  - Response: takes effect at the next `scan_tick`.
- Hex and range:
  - Stimulus: `HEX_EN`=1, write 4'hA.
  - Response: 8'b10001000.
  - Stimulus: `HEX_EN`=0, write 4'hA.
  - Response: 8'hFF.
  - Stimulus: `NUM_DIGITS`=6, write to index 7.
  - Response: no state change.
- Write collision:
  - Stimulus: write digit 2 := 9 in the same cycle slot advances to 2.
  - Response: the first cathode of slot 2 is 8'b10000100.
- Reset mid-operation:
  - Stimulus: assert `rst` with `wr_en`=1 halfway through slot 1.
  - Response: all outputs return to reset values the next cycle, the write is discarded, and the scan restarts at slot N-1.
